// File: rtl/mul_seq_param_if.sv
// ----------------------------------------------------------------------------
// mul_seq_param_if
//   Request/result bundle between the ALU decoder and the sequential
//   multiplier.
//
//   Handshake: the decoder raises start together with dtype/M/Q. A request
//   is taken only while the multiplier is idle (busy=0) and only for a
//   recognised dtype; otherwise it is dropped, never queued. done is a
//   one-cycle pulse marking result valid; result then holds until the next
//   done.
//
//   Signals (master = requester, slave = multiplier)
//     start   m->s  1        request strobe
//     dtype   m->s  4        operation code
//     M       m->s  WIDTH    multiplicand
//     Q       m->s  WIDTH    multiplier
//     busy    s->m  1        operation in progress
//     done    s->m  1        result valid pulse
//     result  s->m  2*WIDTH  full-width product
// ----------------------------------------------------------------------------
interface mul_seq_param_if #(
    parameter int WIDTH = 16
);
    logic                 start;
    logic [3:0]           dtype;
    logic [WIDTH-1:0]     M;
    logic [WIDTH-1:0]     Q;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   result;

    modport master (
        output start, dtype, M, Q,
        input  busy, done, result
    );

    modport slave (
        input  start, dtype, M, Q,
        output busy, done, result
    );
endinterface

// File: rtl/mul_seq_param.sv
// ----------------------------------------------------------------------------
// mul_seq_param
//   Sequential WIDTH x WIDTH multiplier for the calculator ALU. One
//   partial-product step per clock: plain shift-add for unsigned operands,
//   radix-2 Booth for two's-complement operands. Product is 2*WIDTH bits.
//
//   Ports
//     clk      in   1    system clock, rising edge
//     n_rst    in   1    asynchronous active-low reset
//     bus      slave     request/result bundle (mul_seq_param_if)
//     o_state  out  2    FSM state (0 IDLE, 1 CALC, 2 DONE) for observation
// ----------------------------------------------------------------------------
module mul_seq_param #(
    parameter int         WIDTH  = 16,
    parameter logic [3:0] DT_UNS = 4'h1,
    parameter logic [3:0] DT_SGN = 4'h2
) (
    input  logic                    clk,
    input  logic                    n_rst,
    mul_seq_param_if.slave          bus,
    output logic [1:0]              o_state
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    // acc carries one extra bit so Booth never overflows (covers
    // (-2^(W-1)) * (-2^(W-1))) and the unsigned carry has somewhere to live.
    logic [WIDTH:0]      r_acc;
    logic [WIDTH-1:0]    r_q;
    logic                r_qm1;
    logic [WIDTH-1:0]    r_m;
    logic [CW-1:0]       r_cnt;
    logic                r_sgn;
    logic [2*WIDTH-1:0]  r_result;

    logic                w_accept;
    logic                w_last;
    logic [WIDTH:0]      w_m_ext;
    logic [WIDTH:0]      w_sum;
    logic [WIDTH:0]      w_acc_next;
    logic [WIDTH-1:0]    w_q_next;

    assign w_accept = (r_state == S_IDLE) && bus.start &&
                      ((bus.dtype == DT_UNS) || (bus.dtype == DT_SGN));
    assign w_last   = (r_cnt == CW'(1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_CALC;
            S_CALC:  if (w_last)   w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (r_state)
            S_CALC:  bus.busy = 1'b1;
            S_DONE:  begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.result = r_result;
    assign o_state    = r_state;

    // ---------------- step datapath ----------------
    // Unsigned: add M when q[0]=1, acc[WIDTH] is always 0 so the sum's top
    // bit is the carry and a logical shift moves it in.
    // Signed: Booth pair {q[0],q_m1} picks -M / +M / nothing, then an
    // arithmetic shift of {acc,q,q_m1}.
    always_comb begin
        w_m_ext = r_sgn ? {r_m[WIDTH-1], r_m} : {1'b0, r_m};
        w_sum   = r_acc;
        if (r_sgn) begin
            if (r_q[0] && !r_qm1)      w_sum = r_acc - w_m_ext;
            else if (!r_q[0] && r_qm1) w_sum = r_acc + w_m_ext;
        end else if (r_q[0]) begin
            w_sum = r_acc + w_m_ext;
        end
        w_acc_next = {r_sgn & w_sum[WIDTH], w_sum[WIDTH:1]};
        w_q_next   = {w_sum[0], r_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_acc    <= '0;
            r_q      <= '0;
            r_qm1    <= 1'b0;
            r_m      <= '0;
            r_cnt    <= '0;
            r_sgn    <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_m   <= bus.M;
            r_q   <= bus.Q;
            r_acc <= '0;
            r_qm1 <= 1'b0;
            r_cnt <= CW'(WIDTH);
            r_sgn <= (bus.dtype == DT_SGN);
        end else if (r_state == S_CALC) begin
            r_acc <= w_acc_next;
            r_q   <= w_q_next;
            r_qm1 <= r_q[0];
            r_cnt <= r_cnt - CW'(1);
            // Final step lands straight in result as DONE is entered.
            if (w_last) begin
                r_result <= {w_acc_next[WIDTH-1:0], w_q_next};
            end
        end
    end

endmodule

// File: tb/tb_mul_seq_param.sv
// ----------------------------------------------------------------------------
// tb_mul_seq_param
//   Bench for mul_seq_param: a WIDTH=16 instance for the directed scenarios
//   and a WIDTH=8 instance for the randomised reference comparison.
// ----------------------------------------------------------------------------
module tb_mul_seq_param;

    localparam logic [3:0] DT_UNS = 4'h1;
    localparam logic [3:0] DT_SGN = 4'h2;

    // ---------------- clock / reset ----------------
    logic clk;
    logic n_rst;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    mul_seq_param_if #(.WIDTH(16)) if16 ();
    mul_seq_param_if #(.WIDTH(8))  if8  ();
    logic [1:0] st16;
    logic [1:0] st8;

    mul_seq_param #(.WIDTH(16), .DT_UNS(DT_UNS), .DT_SGN(DT_SGN)) dut16 (
        .clk     (clk),
        .n_rst   (n_rst),
        .bus     (if16),
        .o_state (st16)
    );

    mul_seq_param #(.WIDTH(8), .DT_UNS(DT_UNS), .DT_SGN(DT_SGN)) dut8 (
        .clk     (clk),
        .n_rst   (n_rst),
        .bus     (if8),
        .o_state (st8)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q16[$];
    logic [15:0] exp_q8[$];
    logic [31:0] last16;
    int          n_cmp;
    int          n_mis;

    function automatic logic [31:0] model16(input logic [3:0] dt, input logic [15:0] m, input logic [15:0] q);
        longint a, b, p;
        if (dt == DT_SGN) begin
            a = longint'($signed(m));
            b = longint'($signed(q));
        end else begin
            a = longint'(m);
            b = longint'(q);
        end
        p = a * b;
        return p[31:0];
    endfunction

    function automatic logic [15:0] model8(input logic [3:0] dt, input logic [7:0] m, input logic [7:0] q);
        int a, b, p;
        if (dt == DT_SGN) begin
            a = int'($signed(m));
            b = int'($signed(q));
        end else begin
            a = int'(m);
            b = int'(q);
        end
        p = a * b;
        return p[15:0];
    endfunction

    // ---------------- drivers (called at a negedge, DUT idle) ----------------
    task automatic issue16(input logic [3:0] dt, input logic [15:0] m, input logic [15:0] q);
        if16.start = 1'b1;
        if16.dtype = dt;
        if16.M     = m;
        if16.Q     = q;
        @(negedge clk);
        // Operands are free to change once taken.
        if16.start = 1'b0;
        if16.M     = 16'($urandom);
        if16.Q     = 16'($urandom);
    endtask

    task automatic issue8(input logic [3:0] dt, input logic [7:0] m, input logic [7:0] q);
        if8.start = 1'b1;
        if8.dtype = dt;
        if8.M     = m;
        if8.Q     = q;
        @(negedge clk);
        if8.start = 1'b0;
        if8.M     = 8'($urandom);
        if8.Q     = 8'($urandom);
    endtask

    // Waits (bounded) for done; returns what was observed, compares nothing.
    task automatic wait_done16(output logic seen, output logic [31:0] res, output int cyc_out);
        seen = 1'b0; res = '0; cyc_out = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            if (if16.done) begin
                seen = 1'b1; res = if16.result; cyc_out = c;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_done8(output logic seen, output logic [15:0] res);
        seen = 1'b0; res = '0;
        for (int c = 1; c <= 30 && !seen; c++) begin
            if (if8.done) begin
                seen = 1'b1; res = if8.result;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        n_cmp++; if (if16.busy !== 1'b0)   begin n_mis++; $display("FAIL reset_busy16 got %b want 0", if16.busy); end
        n_cmp++; if (if16.done !== 1'b0)   begin n_mis++; $display("FAIL reset_done16 got %b want 0", if16.done); end
        n_cmp++; if (if16.result !== 32'h0) begin n_mis++; $display("FAIL reset_result16 got %h want 0", if16.result); end
        n_cmp++; if (st16 !== 2'd0)        begin n_mis++; $display("FAIL reset_state16 got %0d want 0", st16); end
        n_cmp++; if (if8.busy !== 1'b0)    begin n_mis++; $display("FAIL reset_busy8 got %b want 0", if8.busy); end
        n_cmp++; if (if8.result !== 16'h0) begin n_mis++; $display("FAIL reset_result8 got %h want 0", if8.result); end
    endtask

    task automatic test_unsigned();
        int done_cnt, done_cyc, busy_cnt;
        logic [31:0] e;
        done_cnt = 0; done_cyc = 0; busy_cnt = 0;
        exp_q16.push_back(32'hFFFE0001);
        issue16(DT_UNS, 16'hFFFF, 16'hFFFF);
        for (int cyc = 1; cyc <= 24; cyc++) begin
            if (if16.busy) busy_cnt++;
            if (if16.done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
                n_cmp++;
                if (exp_q16.size() == 0) begin
                    n_mis++; $display("FAIL uns_result unexpected done, result %h", if16.result);
                end else begin
                    e = exp_q16.pop_front();
                    last16 = e;
                    if (if16.result !== e) begin n_mis++; $display("FAIL uns_result got %h want %h", if16.result, e); end
                end
            end
            @(negedge clk);
        end
        n_cmp++; if (done_cnt != 1)  begin n_mis++; $display("FAIL uns_done_count got %0d want 1", done_cnt); end
        n_cmp++; if (done_cyc != 17) begin n_mis++; $display("FAIL uns_done_cycle got %0d want 17", done_cyc); end
        n_cmp++; if (busy_cnt != 17) begin n_mis++; $display("FAIL uns_busy_cycles got %0d want 17", busy_cnt); end
        exp_q16.delete();
    endtask

    task automatic test_signed();
        logic [15:0] ms[12];
        logic [15:0] qs[12];
        logic [3:0]  dts[12];
        logic        seen;
        logic [31:0] res, e;
        int          cyc;
        ms[0] = 16'h8000; qs[0] = 16'h8000; dts[0] = DT_SGN;
        ms[1] = 16'hFFFF; qs[1] = 16'h0003; dts[1] = DT_SGN;
        ms[2] = 16'h8000; qs[2] = 16'h0001; dts[2] = DT_SGN;
        ms[3] = 16'h7FFF; qs[3] = 16'h8000; dts[3] = DT_SGN;
        for (int i = 4; i < 12; i++) begin
            ms[i] = 16'($urandom); qs[i] = 16'($urandom);
            dts[i] = (i % 2 == 0) ? DT_SGN : DT_UNS;
        end
        for (int i = 0; i < 12; i++) begin
            if (i == 0)      exp_q16.push_back(32'h40000000);
            else if (i == 1) exp_q16.push_back(32'hFFFFFFFD);
            else if (i == 2) exp_q16.push_back(32'hFFFF8000);
            else             exp_q16.push_back(model16(dts[i], ms[i], qs[i]));
            issue16(dts[i], ms[i], qs[i]);
            wait_done16(seen, res, cyc);
            n_cmp++;
            e = exp_q16.pop_front();
            last16 = e;
            if (!seen)          begin n_mis++; $display("FAIL sgn_vec%0d timeout, no done", i); end
            else if (res !== e) begin n_mis++; $display("FAIL sgn_vec%0d got %h want %h", i, res, e); end
        end
    endtask

    task automatic test_handshake();
        int done_cnt;
        logic [31:0] e;
        done_cnt = 0;
        exp_q16.push_back(model16(DT_UNS, 16'h0ABC, 16'h0123));
        issue16(DT_UNS, 16'h0ABC, 16'h0123);
        for (int cyc = 1; cyc <= 24; cyc++) begin
            if (if16.done) begin
                done_cnt++;
                n_cmp++;
                if (exp_q16.size() == 0) begin
                    n_mis++; $display("FAIL hs_result extra done, result %h", if16.result);
                end else begin
                    e = exp_q16.pop_front();
                    last16 = e;
                    if (if16.result !== e) begin n_mis++; $display("FAIL hs_result got %h want %h", if16.result, e); end
                end
            end
            if (cyc == 3 || cyc == 17) begin
                if16.start = 1'b1; if16.dtype = DT_SGN;
                if16.M = 16'hFFFF; if16.Q = 16'h7FFF;
            end else begin
                if16.start = 1'b0;
            end
            @(negedge clk);
        end
        n_cmp++; if (done_cnt != 1)     begin n_mis++; $display("FAIL hs_done_count got %0d want 1", done_cnt); end
        n_cmp++; if (if16.busy !== 1'b0) begin n_mis++; $display("FAIL hs_idle_after got busy=%b want 0", if16.busy); end
        exp_q16.delete();
    endtask

    task automatic test_invalid_dtype();
        int busy_seen, done_seen;
        busy_seen = 0; done_seen = 0;
        if16.start = 1'b1; if16.dtype = 4'h3; if16.M = 16'h0005; if16.Q = 16'h0005;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (cyc == 1) if16.start = 1'b0;
            if (if16.busy) busy_seen++;
            if (if16.done) done_seen++;
        end
        n_cmp++; if (busy_seen != 0)      begin n_mis++; $display("FAIL inv_busy got %0d cycles want 0", busy_seen); end
        n_cmp++; if (done_seen != 0)      begin n_mis++; $display("FAIL inv_done got %0d pulses want 0", done_seen); end
        n_cmp++; if (if16.result !== last16) begin n_mis++; $display("FAIL inv_result got %h want %h", if16.result, last16); end
        n_cmp++; if (st16 !== 2'd0)       begin n_mis++; $display("FAIL inv_state got %0d want 0", st16); end
    endtask

    task automatic test_reset_midop();
        int          done_seen;
        logic        seen;
        logic [31:0] res;
        int          cyc;
        done_seen = 0;
        issue16(DT_UNS, 16'h1234, 16'h5678);
        repeat (7) @(negedge clk);
        n_rst = 1'b0;
        #1;
        n_cmp++; if (if16.result !== 32'h0) begin n_mis++; $display("FAIL rst_result got %h want 0", if16.result); end
        n_cmp++; if (if16.busy !== 1'b0)    begin n_mis++; $display("FAIL rst_busy got %b want 0", if16.busy); end
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (st16 !== 2'd0)         begin n_mis++; $display("FAIL rst_state got %0d want 0", st16); end
        n_rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (if16.done) done_seen++;
            @(negedge clk);
        end
        n_cmp++; if (done_seen != 0) begin n_mis++; $display("FAIL rst_no_done got %0d pulses want 0", done_seen); end
        exp_q16.push_back(32'd42);
        issue16(DT_UNS, 16'd7, 16'd6);
        wait_done16(seen, res, cyc);
        n_cmp++;
        last16 = exp_q16.pop_front();
        if (!seen)               begin n_mis++; $display("FAIL rst_then_7x6 timeout, no done"); end
        else if (res !== last16) begin n_mis++; $display("FAIL rst_then_7x6 got %h want %h", res, last16); end
    endtask

    task automatic test_back_to_back8();
        logic        seen;
        logic [15:0] res, e;
        logic [7:0]  m, q;
        logic [3:0]  dt;
        int          bad;
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            dt = (i % 2 == 0) ? DT_UNS : DT_SGN;
            if (i < 2)      begin m = 8'h80; q = 8'h80; end
            else if (i < 4) begin m = 8'hFF; q = 8'hFF; end
            else            begin m = 8'($urandom_range(0, 255)); q = 8'($urandom_range(0, 255)); end
            exp_q8.push_back(model8(dt, m, q));
            issue8(dt, m, q);
            wait_done8(seen, res);
            n_cmp++;
            e = exp_q8.pop_front();
            if (!seen) begin
                n_mis++; bad++;
                if (bad <= 10) $display("FAIL w8_run%0d timeout, no done", i);
            end else if (res !== e) begin
                n_mis++; bad++;
                if (bad <= 10) $display("FAIL w8_run%0d dt=%0d m=%h q=%h got %h want %h", i, dt, m, q, res, e);
            end
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5ms;
        $display("FAIL watchdog simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        n_cmp = 0; n_mis = 0; last16 = '0;
        if16.start = 1'b0; if16.dtype = 4'h0; if16.M = '0; if16.Q = '0;
        if8.start  = 1'b0; if8.dtype  = 4'h0; if8.M  = '0; if8.Q  = '0;
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        test_reset();
        test_unsigned();
        test_signed();
        test_handshake();
        test_invalid_dtype();
        test_reset_midop();
        test_back_to_back8();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
